// File: rtl/mult_pkg.sv
// Shared types and defaults for the multiplier I/O controller.
// Holds the FSM state enum and default operand width/timeout constants.
package mult_pkg;

  localparam int SIZE_DEF    = 8;
  localparam int TIMEOUT_DEF = 4 * SIZE_DEF;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

endpackage

// File: rtl/prod_fifo.sv
// Two-entry product FIFO; dout is the head entry, held while not popped.
// Ports: CLOCK, RESET (async low), push/din, pop, count, valid, dout.
module prod_fifo
  import mult_pkg::*;
#(
  parameter int W = 2 * SIZE_DEF
) (
  input  logic         CLOCK,
  input  logic         RESET,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [1:0]   count,
  output logic         valid,
  output logic [W-1:0] dout
);

  logic [W-1:0] mem [2];
  logic         rd_ptr;
  logic         wr_ptr;
  logic         do_push;
  logic         do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A push into a full buffer is only allowed when the head leaves
  // in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      mem[0] <= '0;
      mem[1] <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign valid = (count != 2'd0);
  assign dout  = mem[rd_ptr];

endmodule

// File: rtl/mult_io_ctrl.sv
// Operand/handshake controller around an external START/END_MULT multiplier.
// Ports: in_* (operand handshake), op_M/op_X/START/END_MULT/product
// (multiplier side), out_* (buffered products), busy, timeout_err, op_count.
module mult_io_ctrl
  import mult_pkg::*;
#(
  parameter int SIZE    = SIZE_DEF,
  parameter int TIMEOUT = 4 * SIZE
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SIZE-1:0]   in_a,
  input  logic [SIZE-1:0]   in_b,
  output logic [SIZE-1:0]   op_M,
  output logic [SIZE-1:0]   op_X,
  output logic              START,
  input  logic              END_MULT,
  input  logic [2*SIZE-1:0] product,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] out_data,
  output logic              busy,
  output logic              timeout_err,
  output logic [15:0]       op_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t        state;
  state_t        next_state;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          accept;
  logic          push;
  logic [1:0]    fifo_cnt;

  assign tmo_hit = (tmo_cnt == TW'(TIMEOUT)) && !END_MULT;
  assign accept  = in_valid && in_ready;

  // State register
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:      if (accept) next_state = ISSUE;
      ISSUE:     next_state = WAIT_DONE;
      WAIT_DONE: if (END_MULT || tmo_hit) next_state = RELEASE;
      RELEASE:   if (!END_MULT) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready = 1'b0;
    busy     = 1'b1;
    push     = 1'b0;
    unique case (1'b1)
      (state == IDLE): begin
        in_ready = (fifo_cnt != 2'd2);
        busy     = 1'b0;
      end
      (state == WAIT_DONE): push = END_MULT;
      default: ;
    endcase
  end

  // START follows the upcoming state so it is glitch-free and drops
  // right after the capture (or timeout) cycle.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      START <= 1'b0;
    end else begin
      START <= (next_state == ISSUE) || (next_state == WAIT_DONE);
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      op_M <= '0;
      op_X <= '0;
    end else if (state == IDLE && accept) begin
      op_M <= in_a;
      op_X <= in_b;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      tmo_cnt     <= '0;
      timeout_err <= 1'b0;
      op_count    <= 16'd0;
    end else begin
      if (state == ISSUE) begin
        tmo_cnt <= '0;
      end else if (state == WAIT_DONE && !END_MULT && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end
      if (state == WAIT_DONE && tmo_hit) begin
        timeout_err <= 1'b1;
      end
      if (push) begin
        op_count <= op_count + 16'd1;
      end
    end
  end

  prod_fifo #(
    .W (2 * SIZE)
  ) u_fifo (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .push  (push),
    .din   (product),
    .pop   (out_valid && out_ready),
    .count (fifo_cnt),
    .valid (out_valid),
    .dout  (out_data)
  );

endmodule
